// File: rtl/dirty_index_scanner.sv
// rtl/dirty_index_scanner.sv - 32-bit line bitmap to 5-bit index scanner with handshake.
// Optional rotating scan origin: define DIRTY_SCAN_ROTATE_EN.
module dirty_index_scanner #(
   parameter int NLINES = 32,
   parameter int IDXW   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [NLINES-1:0] vec_in,
   input  logic              abort,
   input  logic              idx_ready,
   output logic [IDXW-1:0]   idx_out,
   output logic              idx_valid,
   output logic              busy,
   output logic              done,
   output logic [IDXW:0]     count
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   // First set bit at or above org, wrapping 31->0; returns org when v is empty.
   function automatic logic [IDXW-1:0] first_set(input logic [NLINES-1:0] v,
                                                 input logic [IDXW-1:0]   org);
      logic [IDXW-1:0] pos;
      logic [IDXW-1:0] res;
      logic            found;
      res   = org;
      found = 1'b0;
      for (int i = 0; i < NLINES; i++) begin
         pos = org + IDXW'(i);
         if (!found && v[pos]) begin
            res   = pos;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   state_t              r_state, w_state;
   logic [NLINES-1:0]   r_pending, w_pending;
   logic [IDXW-1:0]     r_idx, w_idx;
   logic                r_valid, w_valid;
   logic                r_busy, w_busy;
   logic                r_done, w_done;
   logic [IDXW:0]       r_count, w_count;
   logic                w_hs;
   logic [NLINES-1:0]   w_rem;
   logic [IDXW-1:0]     w_run_org;
   logic [IDXW-1:0]     w_start_org;

`ifdef DIRTY_SCAN_ROTATE_EN
   logic [IDXW-1:0]     r_origin, w_origin;
   logic [IDXW-1:0]     r_last, w_last;
   assign w_run_org   = r_origin;
   assign w_start_org = r_last + {{(IDXW-1){1'b0}}, 1'b1};
`else
   assign w_run_org   = '0;
   assign w_start_org = '0;
`endif

   assign w_hs  = r_valid & idx_ready;
   assign w_rem = r_pending & ~(NLINES'(1) << r_idx);

   always_comb begin
      w_state   = r_state;
      w_pending = r_pending;
      w_idx     = r_idx;
      w_valid   = r_valid;
      w_busy    = r_busy;
      w_done    = 1'b0;
      w_count   = r_count;
`ifdef DIRTY_SCAN_ROTATE_EN
      w_origin  = r_origin;
      w_last    = r_last;
`endif
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state   = S_SCAN;
               w_pending = vec_in;
               w_count   = '0;
               w_busy    = 1'b1;
               w_idx     = first_set(vec_in, w_start_org);
               w_valid   = |vec_in;
`ifdef DIRTY_SCAN_ROTATE_EN
               w_origin  = w_start_org;
`endif
            end
         end
         S_SCAN: begin
            if (w_hs) begin
               w_pending = w_rem;
               w_count   = r_count + {{IDXW{1'b0}}, 1'b1};
`ifdef DIRTY_SCAN_ROTATE_EN
               w_last    = r_idx;
`endif
            end
            // Abort overrides completion but keeps a same-cycle accept in count.
            if (abort) begin
               w_state   = S_IDLE;
               w_pending = '0;
               w_valid   = 1'b0;
               w_busy    = 1'b0;
            end else if (w_pending == '0) begin
               w_state   = S_DONE;
               w_valid   = 1'b0;
               w_done    = 1'b1;
            end else begin
               w_idx     = first_set(w_pending, w_run_org);
               w_valid   = 1'b1;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
         end
         default: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pending <= '0;
         r_idx     <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_count   <= '0;
`ifdef DIRTY_SCAN_ROTATE_EN
         r_origin  <= '0;
         r_last    <= '1;
`endif
      end else begin
         r_state   <= w_state;
         r_pending <= w_pending;
         r_idx     <= w_idx;
         r_valid   <= w_valid;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_count   <= w_count;
`ifdef DIRTY_SCAN_ROTATE_EN
         r_origin  <= w_origin;
         r_last    <= w_last;
`endif
      end
   end

   assign idx_out   = r_idx;
   assign idx_valid = r_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign count     = r_count;

endmodule

// File: doc/dirty_index_scanner.md
Name: dirty_index_scanner

Overview:
- Inverse of the cache's 5-to-32 one-hot line decoder: encodes a 32-bit line bitmap (dirty/valid lines of a set group) back into 5-bit line indices.
- Latches a bitmap snapshot on start, then emits one index per accepted handshake, lowest index first.
- Feeds the writeback/flush path; each set bit of the snapshot is emitted exactly once.

Parameters:
- NLINES, 32, bitmap width; fixed at 32.
- IDXW, 5, index width; log2(NLINES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- vec_in  input  32  line bitmap; sampled on the cycle start is accepted.
- abort  input  1  synchronous cancel of the current run.
- idx_ready  input  1  consumer accepts idx_out.
- idx_out  output  5  current line index.
- idx_valid  output  1  idx_out is valid.
- busy  output  1  run in progress (SCAN or DONE).
- done  output  1  one-cycle pulse when a run completes normally.
- count  output  6  indices accepted in the current or last run, 0..32.

Behaviour:
- Reset values: state=IDLE, pending=0, idx_out=0, idx_valid=0, busy=0, done=0, count=0, last_idx=31.
- States: IDLE, SCAN, DONE. All outputs are registered.
- IDLE:
  - start=1 latches pending<=vec_in, count<=0 and moves to SCAN.
  - start is ignored in every other state.
- SCAN:
  - idx_out = index of the first set bit of pending, searching upward from the scan origin (origin is 0 without the optional feature).
  - idx_valid=1 whenever pending!=0.
  - First index appears the cycle after start is accepted (1-cycle latency).
- Handshake:
  - On idx_valid && idx_ready: that bit of pending clears, count increments, last_idx<=idx_out.
  - The next index is presented the following cycle, so full rate is 1 index/cycle with idx_ready held high.
  - While idx_valid=1 and idx_ready=0, idx_out and idx_valid hold stable.
- Completion:
  - When the last set bit is accepted, the next state is DONE with idx_valid=0.
  - DONE lasts exactly one cycle with done=1, then returns to IDLE.
  - Empty snapshot (vec_in=0): SCAN → DONE with no valid ever asserted; done pulses 2 cycles after start, count=0.
- busy=1 in SCAN and DONE, 0 in IDLE.
- abort:
  - In SCAN: pending<=0, idx_valid<=0, return to IDLE, no done pulse. count keeps the number accepted before the abort.
  - If abort and the final handshake occur in the same cycle, abort wins: that handshake still counts, but there is no done pulse.
  - abort in IDLE or DONE has no effect.
- Async rst mid-run: all registers return to reset values immediately; no done.
- Count saturates naturally at 32; no wrap is possible.

Optional Feature:
- Macro: DIRTY_SCAN_ROTATE_EN
- Defined: the scan origin of each run is (last_idx+1) mod 32, captured at start.
  - Search proceeds upward with wrap 31→0, so the emit order of a run is rotated.
  - last_idx persists across runs and aborts, and resets to 31 (first run origin = 0).
- Undefined: origin is always 0, order is strictly ascending, and last_idx may be omitted.

Test Plan:
- vec_in=0x00000000, start → no idx_valid; done=1 exactly 2 cycles after start; count=0; busy falls with done.
- vec_in=0x80000011, idx_ready=1 → idx_out 0, 4, 31 on consecutive cycles starting 1 cycle after start; done the next cycle; count=3.
- vec_in=0x00000110, idx_ready low for 3 cycles at first valid → idx_out holds 4 with valid=1 for 4 cycles, then 8; count=2.
- vec_in=0xFFFFFFFF, idx_ready=1, start pulsed again mid-run → 32 indices 0..31 back-to-back, second start ignored, count=32.
- vec_in=0x0000000F, abort asserted after 2 accepts → idx_valid drops next cycle, no done, count=2; rst asserted mid-run in a repeat run → all outputs 0 immediately.
- DIRTY_SCAN_ROTATE_EN defined: run 1 vec=0x00000010 emits 4; run 2 vec=0x00000031 → emits 5, 0, 4; count=3.
